// File: rtl/program_sequencer_if.sv
// Sequencer-facing bus: program-memory address/data, ALU handshake and status.
// The sequencer uses the master modport; the memory/ALU environment uses slave.
interface program_sequencer_if #(
    parameter int PC_WIDTH    = 5,
    parameter int RADDR_WIDTH = 3,
    parameter int IMM_WIDTH   = 8
);
    localparam int INSTR_WIDTH = 1 + 2 * RADDR_WIDTH + IMM_WIDTH;

    logic                   go;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   branch;
    logic [PC_WIDTH-1:0]    pc;
    logic                   op_code;
    logic [RADDR_WIDTH-1:0] reg_addr_1;
    logic [RADDR_WIDTH-1:0] reg_addr_2;
    logic [IMM_WIDTH-1:0]   immediate;
    logic                   reg_wr_en;
    logic                   halted;

    modport master (
        input  go, instr, branch,
        output pc, op_code, reg_addr_1, reg_addr_2, immediate, reg_wr_en, halted
    );

    modport slave (
        output go, instr, branch,
        input  pc, op_code, reg_addr_1, reg_addr_2, immediate, reg_wr_en, halted
    );
endinterface

// File: rtl/program_sequencer.sv
// Two-cycle (FETCH/EXEC) program sequencer for a SUBLEQ/MULTI datapath with
// branch, pc wrap-around and self-loop halt detection.
module program_sequencer #(
    parameter int PC_WIDTH    = 5,
    parameter int RADDR_WIDTH = 3,
    parameter int IMM_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    program_sequencer_if.master   bus
);
    localparam int INSTR_WIDTH = 1 + 2 * RADDR_WIDTH + IMM_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PC_WIDTH-1:0]    pc_q;
    logic                   op_q;
    logic [RADDR_WIDTH-1:0] ra_q;
    logic [RADDR_WIDTH-1:0] rb_q;
    logic [IMM_WIDTH-1:0]   imm_q;

    logic                   wr_en;
    logic                   halt_flag;

    // Instruction word fields, MSB to LSB: op, ra, rb, imm.
    logic                   instr_op;
    logic [RADDR_WIDTH-1:0] instr_ra;
    logic [RADDR_WIDTH-1:0] instr_rb;
    logic [IMM_WIDTH-1:0]   instr_imm;

    assign instr_op  = bus.instr[INSTR_WIDTH-1];
    assign instr_ra  = bus.instr[INSTR_WIDTH-2 -: RADDR_WIDTH];
    assign instr_rb  = bus.instr[IMM_WIDTH+RADDR_WIDTH-1 -: RADDR_WIDTH];
    assign instr_imm = bus.instr[IMM_WIDTH-1:0];

    // Only the low PC_WIDTH immediate bits address program memory.
    logic [PC_WIDTH-1:0] target;
    logic                self_loop;

    assign target    = imm_q[PC_WIDTH-1:0];
    assign self_loop = (target == pc_q);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred for state_d.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.go) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  state_d = (bus.branch && self_loop) ? S_HALT : S_FETCH;
            S_HALT:  if (bus.go) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Outputs decoded from the state register alone
    // ---------------------------------------------------------------
    always_comb begin
        wr_en     = 1'b0;
        halt_flag = 1'b0;
        unique case (state_q)
            S_EXEC:  wr_en     = 1'b1;
            S_HALT:  halt_flag = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Program counter
    // ---------------------------------------------------------------
    // A self-loop branch targets pc itself, so the branch path also covers halt.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pc_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE:  pc_q <= '0;
                S_EXEC:  pc_q <= bus.branch ? target : pc_q + 1'b1;
                S_HALT:  if (bus.go) pc_q <= '0;
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Instruction register: loaded on the FETCH edge, stable through EXEC
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            op_q  <= 1'b0;
            ra_q  <= '0;
            rb_q  <= '0;
            imm_q <= '0;
        end else if (state_q == S_FETCH) begin
            op_q  <= instr_op;
            ra_q  <= instr_ra;
            rb_q  <= instr_rb;
            imm_q <= instr_imm;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.op_code    = op_q;
    assign bus.reg_addr_1 = ra_q;
    assign bus.reg_addr_2 = rb_q;
    assign bus.immediate  = imm_q;
    assign bus.reg_wr_en  = wr_en;
    assign bus.halted     = halt_flag;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: steps are queued with their expected
// write-back record; a negedge monitor pops and compares on every write strobe.
module tb_program_sequencer;

    typedef struct packed {
        logic       op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
        logic       br;
    } step_t;

    typedef struct packed {
        logic [4:0] pc;
        logic       op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] imm;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset;

    program_sequencer_if #(.PC_WIDTH(5), .RADDR_WIDTH(3), .IMM_WIDTH(8)) bus ();

    program_sequencer #(.PC_WIDTH(5), .RADDR_WIDTH(3), .IMM_WIDTH(8)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    step_t      prog [16];
    exp_t       sb [$];
    int         n_steps = 0;
    logic [4:0] model_pc;
    logic [3:0] idx = 4'd0;
    logic [3:0] next_idx = 4'd0;
    step_t      cur;

    always_comb cur = prog[idx];
    assign bus.instr  = {cur.op, cur.ra, cur.rb, cur.imm};
    assign bus.branch = cur.br;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Queue one program step; the expected write and next pc come from the
    // architectural branch rule (branch -> imm[4:0], else pc+1 mod 32).
    task automatic add_step(input logic op, input logic [2:0] ra, input logic [2:0] rb,
                            input logic [7:0] imm, input logic br, input bit expect_write);
        prog[n_steps] = '{op, ra, rb, imm, br};
        n_steps++;
        if (expect_write) sb.push_back('{model_pc, op, ra, rb, imm});
        if (br) model_pc = imm[4:0];
        else    model_pc = model_pc + 5'd1;
    endtask

    // Write-back monitor; the step index advances on the edge that ends EXEC.
    always @(negedge clk) begin
        if (bus.reg_wr_en === 1'b1) begin
            exp_t e;
            next_idx = idx + 4'd1;
            check("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("wr_pc",         32'(bus.pc),         32'(e.pc));
                check("wr_op_code",    32'(bus.op_code),    32'(e.op));
                check("wr_reg_addr_1", 32'(bus.reg_addr_1), 32'(e.ra));
                check("wr_reg_addr_2", 32'(bus.reg_addr_2), 32'(e.rb));
                check("wr_immediate",  32'(bus.immediate),  32'(e.imm));
                check("wr_not_halted", 32'(bus.halted),     32'd0);
            end
        end
    end

    always @(posedge clk) idx <= next_idx;

    task automatic wait_halted(input string tag, input logic [4:0] exp_pc);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.halted === 1'b1);
        end
        check({tag, "_halted"}, 32'(seen), 32'd1);
        check({tag, "_pc"},     32'(bus.pc), 32'(exp_pc));
        check({tag, "_no_wr"},  32'(bus.reg_wr_en), 32'd0);
    endtask

    // go held across FETCH and EXEC edges as well, where it must be ignored.
    task automatic restart(input string tag);
        @(negedge clk);
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_pc0"},      32'(bus.pc),        32'd0);
        check({tag, "_unhalted"}, 32'(bus.halted),    32'd0);
        check({tag, "_fetch_wr"}, 32'(bus.reg_wr_en), 32'd0);
        repeat (3) @(negedge clk);
        bus.go = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        for (int i = 0; i < 16; i++) prog[i] = '{1'b0, 3'd0, 3'd0, 8'h00, 1'b1};

        // Run A: start, branch taken at pc 3, masked branch from 17, halt at 7.
        model_pc = 5'd0;
        add_step(1'b1, 3'd2, 3'd0, 8'h05, 1'b0, 1'b1);
        add_step(1'b0, 3'd1, 3'd3, 8'h40, 1'b0, 1'b1);
        add_step(1'b0, 3'd4, 3'd5, 8'h9A, 1'b0, 1'b1);
        add_step(1'b0, 3'd6, 3'd7, 8'h11, 1'b1, 1'b1);
        add_step(1'b1, 3'd3, 3'd3, 8'hC7, 1'b1, 1'b1);
        add_step(1'b0, 3'd5, 3'd1, 8'h07, 1'b1, 1'b1);
        // Run B: branch not taken at pc 3, wrap 31 -> 0, masked self-loop halt at 2.
        model_pc = 5'd0;
        add_step(1'b0, 3'd1, 3'd1, 8'h03, 1'b1, 1'b1);
        add_step(1'b0, 3'd6, 3'd7, 8'h11, 1'b0, 1'b1);
        add_step(1'b1, 3'd7, 3'd2, 8'h1F, 1'b1, 1'b1);
        add_step(1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b1);
        add_step(1'b0, 3'd2, 3'd2, 8'h02, 1'b1, 1'b1);
        add_step(1'b1, 3'd1, 3'd1, 8'hE2, 1'b1, 1'b1);
        // Run C: jump to 9, reset lands mid-EXEC so that write never happens.
        model_pc = 5'd0;
        add_step(1'b0, 3'd0, 3'd0, 8'h09, 1'b1, 1'b1);
        add_step(1'b1, 3'd1, 3'd2, 8'h33, 1'b0, 1'b0);

        n_reset = 1'b0;
        bus.go  = 1'b0;
        #2;
        check("rst_pc",         32'(bus.pc),         32'd0);
        check("rst_op_code",    32'(bus.op_code),    32'd0);
        check("rst_reg_addr_1", 32'(bus.reg_addr_1), 32'd0);
        check("rst_reg_addr_2", 32'(bus.reg_addr_2), 32'd0);
        check("rst_immediate",  32'(bus.immediate),  32'd0);
        check("rst_reg_wr_en",  32'(bus.reg_wr_en),  32'd0);
        check("rst_halted",     32'(bus.halted),     32'd0);

        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_pc",    32'(bus.pc),        32'd0);
            check("idle_no_wr", 32'(bus.reg_wr_en), 32'd0);
        end

        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;

        wait_halted("haltA", 5'd7);
        repeat (10) begin
            @(negedge clk);
            check("haltA_hold_pc",     32'(bus.pc),        32'd7);
            check("haltA_hold_halted", 32'(bus.halted),    32'd1);
            check("haltA_hold_no_wr",  32'(bus.reg_wr_en), 32'd0);
        end

        restart("restartB");
        wait_halted("haltB", 5'd2);

        restart("restartC");
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            found = (bus.reg_wr_en === 1'b1) && (bus.pc === 5'd9);
        end
        check("exec_pc9_reached", 32'(found), 32'd1);
        #1;
        n_reset = 1'b0;
        #1;
        check("arst_wr_en",     32'(bus.reg_wr_en),  32'd0);
        check("arst_pc",        32'(bus.pc),         32'd0);
        check("arst_halted",    32'(bus.halted),     32'd0);
        check("arst_op_code",   32'(bus.op_code),    32'd0);
        check("arst_reg_addr1", 32'(bus.reg_addr_1), 32'd0);
        check("arst_immediate", 32'(bus.immediate),  32'd0);

        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle_pc",    32'(bus.pc),        32'd0);
            check("post_rst_idle_no_wr", 32'(bus.reg_wr_en), 32'd0);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 5, meaning program-counter width (program length 2^PC_WIDTH words).
REQ-002 The block SHALL have parameter RADDR_WIDTH, default 3, meaning register-file address width.
REQ-003 The block SHALL have parameter IMM_WIDTH, default 8, meaning immediate / branch-target field width (IMM_WIDTH >= PC_WIDTH).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 The reset port SHALL be: n_reset  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port go  input  1  start/restart request, level-sensitive, sampled on clk.
REQ-007 The block SHALL have port instr  input  1+2*RADDR_WIDTH+IMM_WIDTH  program-memory word at address pc, combinational read; fields MSB->LSB: op, ra, rb, imm.
REQ-008 The block SHALL have port branch  input  1  branch-taken flag from the ALU, valid during EXEC.
REQ-009 The block SHALL have port pc  output  PC_WIDTH  program-memory address.
REQ-010 The block SHALL have port op_code  output  1  registered op field to the ALU (0 = SUBLEQ, 1 = MULTI).
REQ-011 The block SHALL have port reg_addr_1 / reg_addr_2  output  RADDR_WIDTH each  registered ra / rb; reg_addr_1 is also the write-back address.
REQ-012 The block SHALL have port immediate  output  IMM_WIDTH  registered imm field to the ALU.
REQ-013 The block SHALL have port reg_wr_en  output  1  register-file write strobe for ALU wr_data.
REQ-014 The block SHALL have port halted  output  1  high while in HALT.

Function
REQ-015 The block SHALL implement a four-state FSM: IDLE, FETCH, EXEC, HALT.
REQ-016 In IDLE: pc held at 0; go=1 -> FETCH next cycle; go=0 -> stay.
REQ-017 In FETCH: the instruction register (op_code, reg_addr_1, reg_addr_2, immediate) SHALL load from instr at the clock edge; next state EXEC; pc unchanged.
REQ-018 In EXEC: reg_wr_en=1 for exactly this one cycle; at the clock edge pc SHALL update and the next state SHALL be FETCH, unless the halt condition holds.
REQ-019 Next-pc rule in EXEC: branch=1 -> pc <= immediate[PC_WIDTH-1:0]; branch=0 -> pc <= pc+1 modulo 2^PC_WIDTH.
REQ-020 Wrap-around: pc = 2^PC_WIDTH-1 with branch=0 SHALL give pc = 0; no halt or error results.
REQ-021 Immediate bits above PC_WIDTH SHALL be ignored for branching.
REQ-022 Halt condition: in EXEC, branch=1 and immediate[PC_WIDTH-1:0] == pc (self-loop) -> next state HALT; pc unchanged; the write in that EXEC cycle still occurs.
REQ-023 In HALT: halted=1, reg_wr_en=0, pc held; go=1 -> pc <= 0 and next state FETCH; go=0 -> stay.
REQ-024 go SHALL be ignored in FETCH and EXEC.
REQ-025 branch SHALL be ignored outside EXEC.
REQ-026 Every instruction SHALL take exactly 2 cycles (FETCH+EXEC); throughput is one instruction per 2 cycles.
REQ-027 reg_wr_en and halted SHALL be decoded from the state register only, with no combinational path from any input.
REQ-028 The instruction-register outputs SHALL remain stable from the FETCH edge through the end of EXEC.

Reset
REQ-029 n_reset=0 SHALL immediately, independent of clk, force: state IDLE, pc=0, op_code=0, reg_addr_1=0, reg_addr_2=0, immediate=0, reg_wr_en=0, halted=0.
REQ-030 Reset asserted mid-EXEC SHALL suppress that write (reg_wr_en=0 at once) and discard the pending pc update.
REQ-031 After n_reset deasserts, the block SHALL remain in IDLE until go=1 is sampled.

Verification
REQ-032 Start: reset, go=1 for one cycle, instr at pc 0 = {op=1, ra=2, rb=0, imm=0x05} -> the FETCH edge loads op_code=1, reg_addr_1=2, immediate=0x05; reg_wr_en=1 for exactly one cycle; then pc=1.
REQ-033 Branch: at pc=3, SUBLEQ with imm=0x11 and branch=1 -> pc=17; with branch=0 -> pc=4.
REQ-034 Wrap: at pc=31, branch=0 -> pc=0 and the FSM continues to FETCH.
REQ-035 Halt: at pc=7, imm=0x07 and branch=1 -> the write occurs, halted=1 next cycle, pc stays 7 for 10 cycles with go=0; go=1 -> pc=0, FETCH.
REQ-036 Upper-bit masking: at pc=2, imm=0xE2 and branch=1 -> halt (target 2 == pc).
REQ-037 Async reset: assert n_reset low between edges during EXEC at pc=9 -> reg_wr_en falls without a clock edge, pc=0, state IDLE, and the write never occurs.
